cam_capture: RTL and testbench

Pixel capture engine feeding the camera frame RAM behind the Wishbone camera peripheral. It samples the OV7670-style parallel camera bus (Vsync, Href, Pclk, 8-bit data) in the system clock domain, packs two bytes per pixel into RGB444, and writes one 12-bit word per pixel into the frame RAM. It runs one frame per `start` request and reports the pixel count and completion back to the Wishbone register layer.

---
 rtl/cam_capture_if.sv | 24 ++
 rtl/cam_capture.sv | 187 ++++++++++++++++++
 tb/tb_cam_capture.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_if.sv
// Camera-side and frame-RAM-side signal bundle for cam_capture.
// master = capture engine, slave = camera model / frame RAM.
interface cam_capture_if #(
    parameter int ADDR_W = 17
);
    logic              camera_Vsync;
    logic              camera_Href;
    logic              camera_Pclk;
    logic [7:0]        camera_D;
    logic              camera_Xclk;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [11:0]       ram_data;

    modport master (
        input  camera_Vsync, camera_Href, camera_Pclk, camera_D,
        output camera_Xclk, ram_we, ram_addr, ram_data
    );

    modport slave (
        output camera_Vsync, camera_Href, camera_Pclk, camera_D,
        input  camera_Xclk, ram_we, ram_addr, ram_data
    );
endinterface

// File: rtl/cam_capture.sv
// OV7670-style pixel capture: syncs the camera bus into clk, packs byte pairs into RGB444
// and writes one word per pixel. Define CAM_CAPTURE_ERRCHK_EN to add the frame_err output.
module cam_capture #(
    parameter int FRAME_PIX = 76800,
    parameter int ADDR_W    = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    cam_capture_if.master     cam,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pix_count
`ifdef CAM_CAPTURE_ERRCHK_EN
    ,
    output logic              frame_err
`endif
);
    localparam logic [ADDR_W-1:0] FRAME_CNT = ADDR_W'(FRAME_PIX);

    typedef struct packed {
        logic       vsync;
        logic       href;
        logic       pclk;
        logic [7:0] d;
    } cam_bus_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_CAPTURE,
        S_DONE
    } state_t;

    cam_bus_t          w_cam_in;
    cam_bus_t          r_sync1;
    cam_bus_t          r_sync2;
    logic              r_pclk_hist;
    logic              r_vs_hist;
    logic              w_pclk_rise;
    logic              w_vs_rise;
    logic              w_vs_fall;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_enter_wait;

    logic              r_xclk;
    logic              r_phase;
    logic [3:0]        r_red;
    logic              r_ram_we;
    logic [11:0]       r_ram_data;
    logic [ADDR_W-1:0] r_pix_count;
    logic              w_accept;
    logic              w_room;

    assign w_cam_in = {cam.camera_Vsync, cam.camera_Href, cam.camera_Pclk, cam.camera_D};

    // Href and D travel with Pclk so they are aligned with the edge detected from stage 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_pclk_hist <= 1'b0;
            r_vs_hist   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every stage sampling the previous value.
            r_sync1     <= w_cam_in;
            r_sync2     <= r_sync1;
            r_pclk_hist <= r_sync2.pclk;
            r_vs_hist   <= r_sync2.vsync;
        end
    end

    assign w_pclk_rise = r_sync2.pclk & ~r_pclk_hist;
    assign w_vs_rise   = r_sync2.vsync & ~r_vs_hist;
    assign w_vs_fall   = ~r_sync2.vsync & r_vs_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        w_state_nxt  = r_state;
        w_enter_wait = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_WAIT_VS;
                    w_enter_wait = 1'b1;
                end
            end
            S_WAIT_VS: begin
                busy = 1'b1;
                if (w_vs_fall) w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy = 1'b1;
                if (w_vs_rise) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_nxt  = S_WAIT_VS;
                    w_enter_wait = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A byte arriving together with the closing Vsync edge belongs to no frame.
    assign w_accept = (r_state == S_CAPTURE) && !w_vs_rise && r_sync2.href && w_pclk_rise;
    assign w_room   = (r_pix_count < FRAME_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xclk      <= 1'b0;
            r_phase     <= 1'b0;
            r_red       <= '0;
            r_ram_we    <= 1'b0;
            r_ram_data  <= '0;
            r_pix_count <= '0;
        end else begin
            r_xclk   <= ~r_xclk;
            r_ram_we <= 1'b0;
            if (r_ram_we) begin
                r_pix_count <= r_pix_count + ADDR_W'(1);
            end
            if (w_enter_wait) begin
                r_pix_count <= '0;
                r_phase     <= 1'b0;
            end else if (r_state == S_CAPTURE) begin
                if (!r_sync2.href) begin
                    r_phase <= 1'b0;
                end else if (w_accept) begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_red <= r_sync2.d[3:0];
                    end else if (w_room) begin
                        r_ram_data <= {r_red, r_sync2.d};
                        r_ram_we   <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef CAM_CAPTURE_ERRCHK_EN
    logic              r_ovf;
    logic              r_frame_err;
    logic              w_enter_done;
    logic [ADDR_W-1:0] w_final_count;

    assign w_enter_done  = (r_state == S_CAPTURE) && w_vs_rise;
    // A write may still be pending on the DONE edge, so count it in.
    assign w_final_count = r_pix_count + ADDR_W'(r_ram_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf       <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (w_enter_wait) begin
            r_ovf       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_accept && r_phase && !w_room) r_ovf <= 1'b1;
            if (w_enter_done) r_frame_err <= (w_final_count != FRAME_CNT) || r_ovf;
        end
    end

    assign frame_err = r_frame_err;
`endif

    assign cam.camera_Xclk = r_xclk;
    assign cam.ram_we      = r_ram_we;
    assign cam.ram_addr    = r_pix_count;
    assign cam.ram_data    = r_ram_data;
    assign pix_count       = r_pix_count;
endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture: drives a Pclk = clk/8 camera bus and compares every
// RAM write against a line-level pixel model built from the byte stream.
`timescale 1ns/1ps
module tb_cam_capture;
    localparam int FRAME_PIX = 40;
    localparam int ADDR_W    = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [11:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pix_count;
`ifdef CAM_CAPTURE_ERRCHK_EN
    logic              frame_err;
`endif

    cam_capture_if #(.ADDR_W(ADDR_W)) cif ();

    cam_capture #(
        .FRAME_PIX (FRAME_PIX),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cam       (cif.master),
        .busy      (busy),
        .done      (done),
        .pix_count (pix_count)
`ifdef CAM_CAPTURE_ERRCHK_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    wr_t         wr_q[$];
    logic        prev_we  = 1'b0;
    int          we_wide  = 0;
    logic [11:0] exp_q[$];
    bit          exp_ovf;
    logic [7:0]  line_q[$];

    // Write monitor: records every strobe and counts strobes longer than one cycle.
    always @(negedge clk) begin
        if (cif.ram_we === 1'b1) begin
            wr_q.push_back('{addr: cif.ram_addr, data: cif.ram_data});
            if (prev_we === 1'b1) we_wide <= we_wide + 1;
        end
        prev_we <= cif.ram_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_pixel(input logic [11:0] p);
        if (exp_q.size() < FRAME_PIX) exp_q.push_back(p);
        else exp_ovf = 1'b1;
    endtask

    function automatic logic exp_err();
        return (exp_q.size() != FRAME_PIX) || exp_ovf;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        cif.camera_Href = 1'b1;
        cif.camera_D    = b;
        cif.camera_Pclk = 1'b0;
        tick(4);
        cif.camera_Pclk = 1'b1;
        tick(4);
        cif.camera_Pclk = 1'b0;
    endtask

    // Sends line_q; whole byte pairs become pixels, a trailing odd byte is lost.
    task automatic send_line(input bit close);
        foreach (line_q[i]) send_byte(line_q[i]);
        for (int i = 0; i + 1 < line_q.size(); i += 2) begin
            add_pixel({line_q[i][3:0], line_q[i+1]});
        end
        line_q.delete();
        if (close) begin
            tick(4);
            cif.camera_Href = 1'b0;
            tick(8);
        end
    endtask

    task automatic rand_bytes(input int n);
        for (int i = 0; i < n; i++) line_q.push_back(8'($urandom));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic new_frame();
        exp_q.delete();
        wr_q.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic vs_fall();
        cif.camera_Vsync = 1'b0;
        tick(6);
    endtask

    task automatic vs_rise_wait(input string tag);
        cif.camera_Vsync = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (done === 1'b1) break;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwr"}, wr_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < wr_q.size()) begin
                check({tag, "_addr"}, wr_q[i].addr, i);
                check({tag, "_data"}, wr_q[i].data, exp_q[i]);
            end
        end
        check({tag, "_pix"}, pix_count, exp_q.size());
        check({tag, "_ramaddr"}, cif.ram_addr, exp_q.size());
    endtask

    initial begin
        int len1;
        reset            = 1'b1;
        start            = 1'b0;
        cif.camera_Vsync = 1'b1;
        cif.camera_Href  = 1'b0;
        cif.camera_Pclk  = 1'b0;
        cif.camera_D     = 8'h00;
        tick(3);
        check("rst_xclk", cif.camera_Xclk, 0);
        check("rst_we", cif.ram_we, 0);
        check("rst_busy", busy, 0);

        // Idle after reset: Xclk toggles each clk edge, nothing else moves.
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check("idle_xclk", cif.camera_Xclk, k % 2);
        end
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_pix", pix_count, 0);
        check("idle_addr", cif.ram_addr, 0);
        check("idle_data", cif.ram_data, 0);
        check("idle_nwr", wr_q.size(), 0);
`ifdef CAM_CAPTURE_ERRCHK_EN
        check("idle_err", frame_err, 0);
`endif

        // One line of four pixels, starting 0x0A,0xBC.
        new_frame();
        pulse_start();
        check("A_busy_start", busy, 1);
        check("A_done_start", done, 0);
        vs_fall();
        line_q.push_back(8'h0A);
        line_q.push_back(8'hBC);
        rand_bytes(6);
        send_line(1'b1);
        vs_rise_wait("A");
        compare_writes("A");
        check("A_pix4", pix_count, 4);
        if (wr_q.size() > 0) check("A_first", wr_q[0].data, 12'hABC);
`ifdef CAM_CAPTURE_ERRCHK_EN
        check("A_err", frame_err, exp_err());
`endif

        // Start in DONE, odd-length line, ignored start mid-capture, Vsync rise mid-pixel.
        new_frame();
        pulse_start();
        check("B_busy_start", busy, 1);
        check("B_done_clr", done, 0);
        check("B_pix_clr", pix_count, 0);
        vs_fall();
        len1 = 2 * $urandom_range(1, 4) + 1;
        rand_bytes(len1);
        send_line(1'b1);
        rand_bytes(10);
        send_line(1'b1);
        pulse_start();
        check("B_start_ign_busy", busy, 1);
        check("B_start_ign_pix", pix_count, exp_q.size());
        rand_bytes(5);
        send_line(1'b0);
        vs_rise_wait("B");
        cif.camera_Href = 1'b0;
        tick(4);
        compare_writes("B");
`ifdef CAM_CAPTURE_ERRCHK_EN
        check("B_err", frame_err, exp_err());
`endif

        // Overflow: 45 pixels offered, only FRAME_PIX written.
        new_frame();
        pulse_start();
        vs_fall();
        for (int l = 0; l < 5; l++) begin
            rand_bytes(18);
            send_line(1'b1);
        end
        vs_rise_wait("C");
        compare_writes("C");
        check("C_pix_full", pix_count, FRAME_PIX);
        if (wr_q.size() > 0) check("C_last_addr", wr_q[wr_q.size()-1].addr, FRAME_PIX - 1);
`ifdef CAM_CAPTURE_ERRCHK_EN
        check("C_err", frame_err, exp_err());
`endif

        // Exactly FRAME_PIX pixels.
        new_frame();
        pulse_start();
        vs_fall();
        for (int l = 0; l < 4; l++) begin
            rand_bytes(20);
            send_line(1'b1);
        end
        vs_rise_wait("D");
        compare_writes("D");
`ifdef CAM_CAPTURE_ERRCHK_EN
        check("D_err", frame_err, exp_err());
`endif

        // Reset during capture after 10 pixels plus a pending first byte.
        new_frame();
        pulse_start();
        vs_fall();
        rand_bytes(21);
        send_line(1'b0);
        check("E_nwr_pre", wr_q.size(), 10);
        reset = 1'b1;
        tick(1);
        check("E_busy", busy, 0);
        check("E_done", done, 0);
        check("E_pix", pix_count, 0);
        check("E_we", cif.ram_we, 0);
        check("E_data", cif.ram_data, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        cif.camera_Href = 1'b0;
        tick(8);
        check("E_nwr_post", wr_q.size(), 10);
        check("E_idle_busy", busy, 0);
        check("E_idle_pix", pix_count, 0);

        check("we_one_cycle", we_wide, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
